// File: rtl/move_input_ctrl_if.sv
// Button, board-state and move-request signals between the input stage and its environment.
interface move_input_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_sel;
  logic [8:0] X_state;
  logic [8:0] O_state;
  logic       game_active;
  logic [3:0] nextMove;
  logic       move;
  logic [3:0] cursor;
  logic       reject;
  logic       busy;

  // Environment side: drives buttons and board, observes requests.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, X_state, O_state, game_active,
    input  nextMove, move, cursor, reject, busy
  );

  // Input-stage side.
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, X_state, O_state, game_active,
    output nextMove, move, cursor, reject, busy
  );
endinterface

// File: rtl/move_input_ctrl.sv
// Tic-tac-toe input stage: synchronises and debounces five buttons, moves a 3x3 cursor,
// and issues validated move requests to the game-state block.
module move_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic             clk,
  input  logic             rst,
  move_input_ctrl_if.slave bus
);

  localparam int unsigned NumBtn  = 5;
  localparam logic [15:0] DbLimit = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] AckLast = 16'(ACK_TIMEOUT - 1);

  // Button bit order doubles as event priority: bit 0 wins.
  localparam int unsigned BtnSel   = 0;
  localparam int unsigned BtnUp    = 1;
  localparam int unsigned BtnDown  = 2;
  localparam int unsigned BtnLeft  = 3;
  localparam int unsigned BtnRight = 4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] level_q, level_d;
  logic [NumBtn-1:0] press_q, press_d;
  logic [15:0]       db_cnt_q [NumBtn];
  logic [15:0]       db_cnt_d [NumBtn];

  state_e      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  next_move_q, next_move_d;
  logic        reject_q, reject_d;
  logic [15:0] wait_q, wait_d;
  logic [8:0]  occupied;
  logic [3:0]  cursor_idx;

  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_sel};
  assign occupied   = bus.X_state | bus.O_state;
  assign cursor_idx = 4'(row_q) * 4'd3 + 4'(col_q);

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count disagreeing samples, flip the level when the count would hit the limit.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < NumBtn; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] + 16'd1 == DbLimit) begin
          level_d[i] = ~level_q[i];
          press_d[i] = ~level_q[i];  // only a 0->1 flip is a press
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Debouncer state and registered press events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NumBtn; i++) db_cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < NumBtn; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Next-state logic: one prioritised event per cycle in IDLE, then issue and await the board.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    next_move_d = next_move_q;
    reject_d    = 1'b0;
    wait_d      = wait_q;
    unique case (state_q)
      StIdle: begin
        if (press_q[BtnSel]) begin
          if (bus.game_active && !occupied[cursor_idx]) begin
            next_move_d = cursor_idx;
            state_d     = StIssue;
          end else begin
            reject_d = 1'b1;
          end
        end else if (press_q[BtnUp]) begin
          row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
        end else if (press_q[BtnDown]) begin
          row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
        end else if (press_q[BtnLeft]) begin
          col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
        end else if (press_q[BtnRight]) begin
          col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end
      end
      StIssue: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        if (occupied[next_move_q] || !bus.game_active || wait_q == AckLast) begin
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, cursor and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= 2'd1;
      col_q       <= 2'd1;
      next_move_q <= '0;
      reject_q    <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      next_move_q <= next_move_d;
      reject_q    <= reject_d;
      wait_q      <= wait_d;
    end
  end

  assign bus.nextMove = next_move_q;
  assign bus.cursor   = cursor_idx;
  assign bus.reject   = reject_q;
  assign bus.move     = (state_q == StIssue);
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: doc/move_input_ctrl.md
# move_input_ctrl

Upstream input stage for the tic-tac-toe game-state block. It debounces five raw push-buttons, moves a 3x3 board cursor, and validates selections against the current board occupancy. It issues a one-cycle `move` pulse with `nextMove` only for free cells while a game is active, then holds off further input until the game state shows the cell filled.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required to change a debounced level; legal range 2..65535.
- `ACK_TIMEOUT`, default 8: maximum cycles spent waiting for the board update after a move pulse.
- `clk  in  1`: system clock; all state changes on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel`  `in  1` each: raw, unsynchronised buttons, active-high.
- `X_state  in  9`: X occupancy; bit i is cell i, row-major, i = row*3 + col.
- `O_state  in  9`: O occupancy; same encoding.
- `game_active  in  1`: 1 while a game is in progress; 0 after a win or draw.
- `nextMove  out  4`: index of the requested cell, 0..8; held stable until the next accepted selection.
- `move  out  1`: one-cycle request pulse to the game state.
- `cursor  out  4`: current cursor index, 0..8, for display.
- `reject  out  1`: one-cycle pulse when a selection is refused.
- `busy  out  1`: high in ISSUE and WAIT states.

## Operation
- Each raw button passes through a 2-flop synchroniser, then its own debouncer.
- Debouncer:
  - A counter increments while the synchronised input differs from the debounced level, and clears when they agree.
  - When the counter would reach DEBOUNCE_CYCLES, the level flips and the counter clears.
  - A press event is a 0->1 flip of the debounced level. A 1->0 flip produces no event.
- Only one press event is acted on per cycle. Priority: sel > up > down > left > right. Lower-priority simultaneous events are discarded, not queued.
- Cursor moves, with wrap-around within the row or column:
  - up: row = (row+2)%3
  - down: row = (row+1)%3
  - left: col = (col+2)%3
  - right: col = (col+1)%3
- Cursor moves are allowed in IDLE only. They are ignored in ISSUE and WAIT.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE, sel event, `game_active`=1, and bit `cursor` of (X_state|O_state) is 0 -> latch `nextMove`=`cursor`, go to ISSUE.
  - IDLE, sel event, and either the cell is occupied or `game_active`=0 -> pulse `reject`, stay in IDLE.
  - ISSUE -> `move`=1 for exactly this cycle, go to WAIT, clear the wait counter.
  - WAIT -> return to IDLE when bit `nextMove` of (X_state|O_state) is 1, or when the wait counter reaches ACK_TIMEOUT-1, or when `game_active` falls.
- All input events are ignored in ISSUE and WAIT, including sel.
- Debouncers keep running in every state. A held button produces no new event on return to IDLE.

## Timing
- Reset values:
  - `cursor`=4 (centre), `nextMove`=0, `move`=0, `reject`=0, `busy`=0.
  - FSM = IDLE.
  - All debounced levels = 0; all counters and synchroniser flops = 0.
- Button latency:
  - Raw input high from before edge 1 -> synchronised by edge 2 -> debounced level high after edge 2+DEBOUNCE_CYCLES.
  - The action (cursor update, ISSUE entry, or `reject`) is registered at the following edge.
- Move path:
  - `move` is high in the cycle after ISSUE entry and lasts one cycle.
  - `busy` is high from ISSUE entry until WAIT exit.
  - `nextMove` is valid from ISSUE entry and at least until the next accepted sel.
- A board update already visible in the first WAIT cycle causes exit at the end of that cycle.
- A timeout with no board update returns to IDLE silently. No retry and no `reject`.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Asserting `rst` mid-debounce, in ISSUE, or in WAIT returns every output to its reset value immediately. `move` never completes a partial pulse.

## Test plan
- Reset, DEBOUNCE_CYCLES=4, press right once for 10 cycles -> `cursor` goes 4->5. Press right again -> `cursor`=3 (row wrap).
- From `cursor`=4, press up twice -> `cursor`=1, then 7 (column wrap). Press left at `cursor`=6 -> `cursor`=8.
- Board empty, `game_active`=1, `cursor`=4, press sel -> exactly one `move` pulse with `nextMove`=4 and `busy`=1. Set bit 4 of `X_state` two cycles later -> `busy`=0 on the next edge.
- `O_state`=9'b000010000, `cursor`=4, press sel -> `reject` pulses once, `move` stays 0, FSM stays in IDLE. Same with cell empty and `game_active`=0 -> `reject`.
- Press sel and right together -> only the sel action occurs and `cursor` is unchanged. A 3-cycle glitch on `btn_up` with DEBOUNCE_CYCLES=4 -> no cursor change.
- Press sel and never update the board, ACK_TIMEOUT=8 -> `busy` drops after 8 WAIT cycles. Assert `rst` during WAIT -> all outputs at reset values and `cursor`=4.
